// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared types, constants and the US Set-2 to ASCII lookup for the PS/2 decoder.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0,
    ST_SKIP
  } state_t;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_F0 = 8'hF0;
  localparam logic [7:0] PFX_E1 = 8'hE1;

  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CAPS   = 8'h58;

  // Bytes that follow E1 in the Pause sequence: 14 77 E1 F0 14 F0 77.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // One decoded key event as stored in the event FIFO.
  typedef struct packed {
    logic [7:0] ascii;
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  // Keyboard replies (ACK, BAT result, echo, resend, errors) carry no key information.
  function automatic logic is_discard(input logic [7:0] code);
    case (code)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

  // US layout: letters honour shift^caps, digits honour shift only.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code,
                                               input logic       shift,
                                               input logic       caps);
    logic [7:0] lower;
    logic [7:0] res;
    lower = 8'h00;
    res   = 8'h00;
    case (code)
      8'h1C: lower = 8'h61; 8'h32: lower = 8'h62; 8'h21: lower = 8'h63;
      8'h23: lower = 8'h64; 8'h24: lower = 8'h65; 8'h2B: lower = 8'h66;
      8'h34: lower = 8'h67; 8'h33: lower = 8'h68; 8'h43: lower = 8'h69;
      8'h3B: lower = 8'h6A; 8'h42: lower = 8'h6B; 8'h4B: lower = 8'h6C;
      8'h3A: lower = 8'h6D; 8'h31: lower = 8'h6E; 8'h44: lower = 8'h6F;
      8'h4D: lower = 8'h70; 8'h15: lower = 8'h71; 8'h2D: lower = 8'h72;
      8'h1B: lower = 8'h73; 8'h2C: lower = 8'h74; 8'h3C: lower = 8'h75;
      8'h2A: lower = 8'h76; 8'h1D: lower = 8'h77; 8'h22: lower = 8'h78;
      8'h35: lower = 8'h79; 8'h1A: lower = 8'h7A;
      8'h16: res = shift ? 8'h21 : 8'h31;
      8'h1E: res = shift ? 8'h40 : 8'h32;
      8'h26: res = shift ? 8'h23 : 8'h33;
      8'h25: res = shift ? 8'h24 : 8'h34;
      8'h2E: res = shift ? 8'h25 : 8'h35;
      8'h36: res = shift ? 8'h5E : 8'h36;
      8'h3D: res = shift ? 8'h26 : 8'h37;
      8'h3E: res = shift ? 8'h2A : 8'h38;
      8'h46: res = shift ? 8'h28 : 8'h39;
      8'h45: res = shift ? 8'h29 : 8'h30;
      8'h29: res = 8'h20;
      8'h5A: res = 8'h0D;
      8'h66: res = 8'h08;
      default: res = 8'h00;
    endcase
    if (lower != 8'h00) begin
      res = (shift ^ caps) ? (lower - 8'h20) : lower;
    end
    return res;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO with extra-MSB pointers for full/empty detection.
// Latency: a write is visible at the head the cycle after the push edge (no bypass).
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module ps2_event_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Head reads as zero when empty so the fields are clean straight out of reset.
  assign head  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; a full FIFO still accepts a push when it is popped in the same cycle.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + (do_push ? (AW+1)'(1) : (AW+1)'(0));
    rd_ptr_d = rd_ptr_q + (do_pop  ? (AW+1)'(1) : (AW+1)'(0));
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Strips E0/F0/E1 prefixes from Set-2 bytes, tracks Shift/Caps and queues key events.
// Latency: 1 cycle from scanValid to evtValid.
// Backpressure: none upstream; a full FIFO drops the event and sets sticky overflow.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scanValid,
  input  logic [7:0] scanCode,
  output logic       evtValid,
  input  logic       evtReady,
  output logic [7:0] evtCode,
  output logic       evtBreak,
  output logic       evtExtended,
  output logic [7:0] evtAscii,
  output logic       shiftHeld,
  output logic       capsLock,
  output logic       overflow
);

  state_t     state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic       shift_l_q, shift_l_d;
  logic       shift_r_q, shift_r_d;
  logic       caps_lock_q, caps_lock_d;
  logic       caps_down_q, caps_down_d;
  logic       overflow_q, overflow_d;

  logic       push;
  logic       pop;
  logic       evt_brk;
  logic       evt_ext;
  logic [7:0] evt_ascii;
  logic       fifo_full;
  logic       fifo_empty;
  evt_t       wr_evt;
  evt_t       head_evt;

  assign pop       = !fifo_empty && evtReady;
  assign shiftHeld = shift_l_q | shift_r_q;
  assign capsLock  = caps_lock_q;
  assign overflow  = overflow_q;

  // Prefix FSM: decides whether this byte completes an event and with which flags.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    push    = 1'b0;
    evt_brk = 1'b0;
    evt_ext = 1'b0;
    if (scanValid) begin
      case (state_q)
        ST_IDLE: begin
          if (scanCode == PFX_E0) begin
            state_d = ST_GOT_E0;
          end else if (scanCode == PFX_F0) begin
            state_d = ST_GOT_F0;
          end else if (scanCode == PFX_E1) begin
            state_d = ST_SKIP;
            skip_d  = PAUSE_SKIP;
          end else if (!is_discard(scanCode)) begin
            push = 1'b1;
          end
        end
        ST_GOT_E0: begin
          if (scanCode == PFX_F0) begin
            state_d = ST_GOT_E0F0;
          end else if (scanCode != PFX_E0) begin
            push    = 1'b1;
            evt_ext = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          if (scanCode != PFX_F0) begin
            push    = 1'b1;
            evt_brk = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_GOT_E0F0: begin
          if (scanCode != PFX_F0) begin
            push    = 1'b1;
            evt_brk = 1'b1;
            evt_ext = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) begin
            skip_d  = 3'd0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Modifier tracking and ASCII translation; ASCII uses the state before this byte.
  always_comb begin
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    caps_lock_d = caps_lock_q;
    caps_down_d = caps_down_q;
    evt_ascii   = 8'h00;
    if (push && !evt_ext && !evt_brk) begin
      evt_ascii = scan_to_ascii(scanCode, shiftHeld, caps_lock_q);
    end
    if (push && !evt_ext) begin
      case (scanCode)
        KEY_LSHIFT: shift_l_d = !evt_brk;
        KEY_RSHIFT: shift_r_d = !evt_brk;
        KEY_CAPS: begin
          if (evt_brk) begin
            caps_down_d = 1'b0;
          end else begin
            // Typematic repeats arrive with caps_down set and must not re-toggle.
            if (!caps_down_q) begin
              caps_lock_d = !caps_lock_q;
            end
            caps_down_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    overflow_d = overflow_q | (push & fifo_full & ~pop);
  end

  // Decoder state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      skip_q      <= 3'd0;
      shift_l_q   <= 1'b0;
      shift_r_q   <= 1'b0;
      caps_lock_q <= 1'b0;
      caps_down_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      caps_lock_q <= caps_lock_d;
      caps_down_q <= caps_down_d;
      overflow_q  <= overflow_d;
    end
  end

  assign wr_evt = '{ascii: evt_ascii, ext: evt_ext, brk: evt_brk, code: scanCode};

  ps2_event_fifo #(
    .WIDTH ($bits(evt_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .wr_dat (wr_evt),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (head_evt)
  );

  assign evtValid    = !fifo_empty;
  assign evtCode     = head_evt.code;
  assign evtBreak    = head_evt.brk;
  assign evtExtended = head_evt.ext;
  assign evtAscii    = head_evt.ascii;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder with a byte-level reference model.
// Latency: model events are expected one cycle after the byte is presented.
// Backpressure: evtReady is held low, pulsed or randomised to exercise FIFO full/drop.
module tb_ps2_scancode_decoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       scanValid;
  logic [7:0] scanCode;
  logic       evtValid;
  logic       evtReady;
  logic [7:0] evtCode;
  logic       evtBreak;
  logic       evtExtended;
  logic [7:0] evtAscii;
  logic       shiftHeld;
  logic       capsLock;
  logic       overflow;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .scanValid   (scanValid),
    .scanCode    (scanCode),
    .evtValid    (evtValid),
    .evtReady    (evtReady),
    .evtCode     (evtCode),
    .evtBreak    (evtBreak),
    .evtExtended (evtExtended),
    .evtAscii    (evtAscii),
    .shiftHeld   (shiftHeld),
    .capsLock    (capsLock),
    .overflow    (overflow)
  );

  typedef struct {
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic [7:0] ascii;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   n_popped = 0;
  bit   rdy;

  // Reference model state: pending prefixes, bytes left to skip, modifiers, occupancy.
  bit m_e0, m_f0, m_shl, m_shr, m_caps, m_cdown, m_ovf;
  int m_skip, occ;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_ascii(input logic [7:0] c, input bit sh, input bit cp);
    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                 8'h35, 8'h1A};
    logic [7:0] digits [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                8'h46, 8'h45};
    string plain   = "1234567890";
    string shifted = "!@#$%^&*()";
    for (int i = 0; i < 26; i++)
      if (letters[i] == c) return 8'((sh ^ cp) ? ("A" + i) : ("a" + i));
    for (int i = 0; i < 10; i++)
      if (digits[i] == c) return sh ? shifted[i] : plain[i];
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    if (c == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  // Applies one cycle of input to the model: decode the byte, then account for FIFO space.
  task automatic model_step(input bit v, input logic [7:0] b, input bit r);
    bit   have = 0;
    bit   popping = (occ > 0) && r;
    exp_t ev;
    if (v) begin
      if (m_skip > 0) begin
        m_skip--;
      end else if (b == 8'hE1 && !m_e0 && !m_f0) begin
        m_skip = 7;
      end else if (b == 8'hE0 && !m_f0) begin
        m_e0 = 1;
      end else if (b == 8'hF0) begin
        m_f0 = 1;
      end else if (!m_e0 && !m_f0 &&
                   (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF})) begin
        have = 0;
      end else begin
        have   = 1;
        ev.code = b;
        ev.brk  = m_f0;
        ev.ext  = m_e0;
        m_e0 = 0;
        m_f0 = 0;
      end
    end
    if (have) begin
      ev.ascii = (!ev.brk && !ev.ext) ? model_ascii(b, m_shl | m_shr, m_caps) : 8'h00;
      if (!ev.ext) begin
        if (b == 8'h12) m_shl = !ev.brk;
        if (b == 8'h59) m_shr = !ev.brk;
        if (b == 8'h58) begin
          if (ev.brk) m_cdown = 0;
          else begin
            if (!m_cdown) m_caps = !m_caps;
            m_cdown = 1;
          end
        end
      end
      if (occ == DEPTH && !popping) m_ovf = 1;
      else begin
        exp_q.push_back(ev);
        occ++;
      end
    end
    if (popping) occ--;
  endtask

  task automatic cyc(input bit v, input logic [7:0] b);
    scanValid = v;
    scanCode  = b;
    evtReady  = rdy;
    model_step(v, b, rdy);
    @(posedge clk);
    #1;
    scanValid = 1'b0;
    scanCode  = 8'h00;
    check("shift_held", 8'(shiftHeld), 8'(m_shl | m_shr));
    check("caps_lock",  8'(capsLock),  8'(m_caps));
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b);
  endtask

  task automatic pop_one();
    rdy = 1;
    cyc(1'b0, 8'h00);
    rdy = 0;
  endtask

  task automatic expect_head(input string name, input logic [7:0] code, input bit brk,
                             input bit ext, input logic [7:0] ascii);
    check({name, "_valid"}, 8'(evtValid),    8'h01);
    check({name, "_code"},  evtCode,         code);
    check({name, "_brk"},   8'(evtBreak),    8'(brk));
    check({name, "_ext"},   8'(evtExtended), 8'(ext));
    check({name, "_ascii"}, evtAscii,        ascii);
  endtask

  task automatic do_reset();
    scanValid = 1'b0;
    scanCode  = 8'h00;
    rdy       = 0;
    evtReady  = 1'b0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_e0 = 0; m_f0 = 0; m_shl = 0; m_shr = 0; m_caps = 0; m_cdown = 0; m_ovf = 0;
    m_skip = 0;
    occ = 0;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    int budget = 100;
    rdy = 1;
    while (exp_q.size() > 0 && budget > 0) begin
      cyc(1'b0, 8'h00);
      budget--;
    end
    rdy = 0;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_drain_timeout: %0d events still expected", name, exp_q.size());
      exp_q.delete();
    end
    cyc(1'b0, 8'h00);
    check({name, "_empty"}, 8'(evtValid), 8'h00);
  endtask

  // Monitor: every accepted event must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && evtValid && evtReady) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_evt: got code 0x%0h, expected no event", evtCode);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_code",  evtCode,              e.code);
        check("sb_brk",   8'(evtBreak),         8'(e.brk));
        check("sb_ext",   8'(evtExtended),      8'(e.ext));
        check("sb_ascii", evtAscii,             e.ascii);
        n_popped++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] keys [20] = '{8'h1C, 8'h32, 8'h21, 8'h24, 8'h1A, 8'h35, 8'h16, 8'h1E,
                              8'h45, 8'h36, 8'h29, 8'h5A, 8'h66, 8'h12, 8'h59, 8'h58,
                              8'h58, 8'h75, 8'h0D, 8'h76};
    logic [7:0] pause [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    logic [7:0] disc  [8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    int popped0;

    do_reset();
    check("rst_valid",    8'(evtValid),    8'h00);
    check("rst_code",     evtCode,         8'h00);
    check("rst_brk",      8'(evtBreak),    8'h00);
    check("rst_ext",      8'(evtExtended), 8'h00);
    check("rst_ascii",    evtAscii,        8'h00);
    check("rst_shift",    8'(shiftHeld),   8'h00);
    check("rst_caps",     8'(capsLock),    8'h00);
    check("rst_overflow", 8'(overflow),    8'h00);

    // Plain make/break of 'a'.
    send(8'h1C);
    expect_head("a_make", 8'h1C, 0, 0, 8'h61);
    pop_one();
    send(8'hF0); send(8'h1C);
    expect_head("a_break", 8'h1C, 1, 0, 8'h00);
    pop_one();

    // Shift then 'A', release, then '1'.
    send(8'h12);
    expect_head("shift_make", 8'h12, 0, 0, 8'h00);
    check("shift_down", 8'(shiftHeld), 8'h01);
    pop_one();
    send(8'h1C);
    expect_head("shift_A", 8'h1C, 0, 0, 8'h41);
    pop_one();
    send(8'hF0); send(8'h12);
    expect_head("shift_break", 8'h12, 1, 0, 8'h00);
    check("shift_up", 8'(shiftHeld), 8'h00);
    pop_one();
    send(8'h16);
    expect_head("digit_1", 8'h16, 0, 0, 8'h31);
    pop_one();

    // Caps Lock with typematic repeat.
    send(8'h58);
    check("caps_on", 8'(capsLock), 8'h01);
    pop_one();
    send(8'h58);
    check("caps_repeat", 8'(capsLock), 8'h01);
    pop_one();
    send(8'hF0); send(8'h58);
    pop_one();
    send(8'h1C);
    expect_head("caps_A", 8'h1C, 0, 0, 8'h41);
    pop_one();

    // Extended make and break.
    send(8'hE0); send(8'h75);
    expect_head("ext_make", 8'h75, 0, 1, 8'h00);
    pop_one();
    send(8'hE0); send(8'hF0); send(8'h75);
    expect_head("ext_break", 8'h75, 1, 1, 8'h00);
    pop_one();

    // Pause sequence produces nothing; the following space does.
    foreach (pause[i]) send(pause[i]);
    check("pause_silent", 8'(evtValid), 8'h00);
    send(8'h29);
    expect_head("space", 8'h29, 0, 0, 8'h20);
    pop_one();

    // Overflow: five makes into a depth-4 FIFO with the consumer stalled.
    do_reset();
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    check("ovf_before", 8'(overflow), 8'h00);
    send(8'h24);
    check("ovf_set", 8'(overflow), 8'h01);
    popped0 = n_popped;
    drain("ovf");
    check("ovf_count", 8'(n_popped - popped0), 8'd4);
    check("ovf_sticky", 8'(overflow), 8'h01);

    // Reset in the middle of an E0 sequence.
    send(8'hE0);
    do_reset();
    check("midrst_overflow", 8'(overflow), 8'h00);
    send(8'h1C);
    expect_head("midrst", 8'h1C, 0, 0, 8'h61);
    pop_one();

    // Randomised byte stream with random consumer stalls.
    do_reset();
    repeat (300) begin
      int kind;
      logic [7:0] k;
      kind = $urandom_range(0, 9);
      k = keys[$urandom_range(0, 19)];
      rdy = ($urandom_range(0, 3) != 0);
      case (kind)
        0, 1, 2, 3: begin
          if ($urandom_range(0, 1) == 1) send(8'hF0);
          send(k);
        end
        4: send(k);
        5: begin
          send(8'hE0);
          if ($urandom_range(0, 1) == 1) send(8'hF0);
          send(k);
        end
        6: foreach (pause[i]) send(pause[i]);
        7: send(disc[$urandom_range(0, 7)]);
        8: send(8'($urandom_range(0, 255)));
        default: cyc(1'b0, 8'h00);
      endcase
    end
    // Let any pending E1 skip window expire before draining.
    repeat (8) send(8'h29);
    drain("rand");
    check("rand_overflow", 8'(overflow), 8'(m_ovf));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
